npc_ctrl: RTL and testbench
===========================

// Module: npc_ctrl
// PURPOSE
//  Fetch-side consumer of the D-stage comparator flags (isSame, isNega).
//  Owns the F-stage PC register and turns the D-stage nPC_sel plus the flags
//  into the next fetch address.
//  Handles the architectural delay slot, branch-likely delay-slot squash, and
//  stall freeze. Keeps a saturating count of taken redirects for testbench
//  trace checks.
// PARAMETERS
//  PC_RESET   32'h0000_3000  F_PC value after reset (text segment base)
//  CNT_WIDTH  16             width of taken-redirect counter
// PORTS
//  clk          in   1          single clock, rising edge
//  reset        in   1          asynchronous, active-low; 0 = reset asserted
//  stall        in   1          hazard-unit freeze of the F and D stages
//  D_PC         in   32         PC of the instruction in D (branch/jump owner)
//  D_nPC_sel    in   3          next-PC select of the D instruction (NPC_* codes)
//  D_imm26      in   26         instr[25:0]; imm16 = D_imm26[15:0]
//  D_RD1        in   32         forwarded rs value (jr target)
//  isSame       in   1          comparator: rs == rt
//  isNega       in   1          comparator: rs == -rt (incl. both zero)
//  F_PC         out  32         current fetch address (registered)
//  D_flush      out  1          clear F->D register at next edge (likely squash)
//  redirect     out  1          registered: last PC update was a taken redirect
//  taken_cnt    out  CNT_WIDTH  saturating count of taken redirects
// BEHAVIOUR
//  Reset (async, level): F_PC=PC_RESET, redirect=0, taken_cnt=0.
//   Takes effect immediately on reset=0, mid-stall or mid-redirect alike.
//   First edge after release fetches PC_RESET+4 unless D holds a jump.
//  Taken decode (combinational from D_nPC_sel and the flags):
//   NPC_PC4=0  never taken
//   NPC_BEQ=1  taken = isSame
//   NPC_BNE=2  taken = !isSame
//   NPC_BNEG=3 taken = isNega
//   NPC_BEQL=4 taken = isSame; likely form
//   NPC_J=5    always taken (j/jal)
//   NPC_JR=6   always taken (jr/jalr)
//   code 7     treated as NPC_PC4, never taken, never flushes
//  Target, 32-bit modulo arithmetic, no overflow detection:
//   branch: D_PC + 4 + (sext(imm16) << 2)
//   J:      {D_PC[31:28], D_imm26, 2'b00}
//   JR:     D_RD1 loaded verbatim, misaligned values included (no exception in P5)
//  Next PC: taken ? target : F_PC + 4.
//   The delay slot is already in F when D resolves, so F_PC+4 is the fall-through.
//  Update: on posedge, if !stall, F_PC <= next PC and redirect <= taken.
//   If stall: F_PC, redirect and taken_cnt all hold.
//   The branch is re-evaluated next cycle with fresh forwarded data.
//  D_flush, combinational: (D_nPC_sel==NPC_BEQL) && !isSame && !stall.
//   Stall always wins: no flush while frozen.
//  taken_cnt: +1 per non-stalled edge with taken=1; saturates at all-ones, no wrap.
//  Latency: one cycle from D resolution to F_PC showing the target.
//   Zero-cycle combinational path from flags to D_flush.
//  Wrap: F_PC+4 from 32'hFFFF_FFFC wraps to 0; no special handling.
// STRUCTURE
//  constants.v: NPC_* codes (3-bit) and `PC_RESET default, shared with
//   controller and cmp.
//  Sub-module npc_target: combinational target adder/mux
//   (inputs D_PC, imm26, RD1, sel). This block keeps the register, taken
//   decode, flush and counter.
// TESTING
//  Reset low mid-run at F_PC=0x3010 -> F_PC=0x3000 same cycle, taken_cnt=0;
//   after release -> 0x3004, 0x3008.
//  D_PC=0x3000, BEQ, imm16=0x0003, isSame=1 -> next F_PC=0x3010, redirect=1,
//   taken_cnt=1. With isSame=0 -> F_PC+4.
//  BEQL with isSame=0 -> D_flush=1 for one cycle, F_PC+4.
//   Same with stall=1 -> D_flush=0, F_PC holds.
//  JR with D_RD1=0x0000_3FFE -> F_PC=0x3FFE. J with D_PC=0x3000,
//   imm26=0x0000C10 -> F_PC=0x0000_3040.
//  Branch taken while stall=1 for 3 cycles, then released -> F_PC frozen
//   3 cycles, single redirect, taken_cnt increments once.
//  CNT_WIDTH=2, five taken branches -> taken_cnt sticks at 3. BNEG with
//   isNega=1, imm16=0xFFFF at D_PC=0x3008 -> F_PC=0x3008.

Source files
------------

// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg
//  Shared next-PC select codes, reset default and small helpers for the
//  fetch-side next-PC controller.
//  Contents:
//   NPC_*             3-bit next-PC select codes driven by the D-stage controller
//   PC_RESET_DEFAULT  text segment base fetched after reset
//   npcDecode_t       decoded view of one D-stage select: taken / likely form
//   npcDecode()       taken decode from select code and comparator flags
//   sext16()          sign extension of a 16-bit immediate to 32 bits
package npc_ctrl_pkg;

    localparam logic [2:0] NPC_PC4  = 3'd0;
    localparam logic [2:0] NPC_BEQ  = 3'd1;
    localparam logic [2:0] NPC_BNE  = 3'd2;
    localparam logic [2:0] NPC_BNEG = 3'd3;
    localparam logic [2:0] NPC_BEQL = 3'd4;
    localparam logic [2:0] NPC_J    = 3'd5;
    localparam logic [2:0] NPC_JR   = 3'd6;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic taken;   // D instruction redirects fetch
        logic likely;  // branch-likely form: delay slot squashed when not taken
    } npcDecode_t;

    // Code 7 and NPC_PC4 fall through to the default: never taken, never likely.
    function automatic npcDecode_t npcDecode(input logic [2:0] sel,
                                             input logic       isSame,
                                             input logic       isNega);
        npcDecode_t d;
        d.taken  = 1'b0;
        d.likely = 1'b0;
        case (sel)
            NPC_BEQ:  d.taken = isSame;
            NPC_BNE:  d.taken = !isSame;
            NPC_BNEG: d.taken = isNega;
            NPC_BEQL: begin
                d.taken  = isSame;
                d.likely = 1'b1;
            end
            NPC_J:    d.taken = 1'b1;
            NPC_JR:   d.taken = 1'b1;
            default:  ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/npc_ctrl_if.sv
// npc_ctrl_if
//  Bundle between the D stage (decode/forwarding/comparator side) and the
//  fetch-side next-PC controller.
//  Signals:
//   stall      hazard-unit freeze of F and D
//   D_PC       PC of the instruction in D
//   D_nPC_sel  next-PC select code of the D instruction
//   D_imm26    instr[25:0]; low 16 bits are the branch immediate
//   D_RD1      forwarded rs value (register jump target)
//   isSame     comparator: rs == rt
//   isNega     comparator: rs == -rt
//   F_PC       registered fetch address
//   D_flush    squash the F->D register at the next edge
//   redirect   last PC update was a taken redirect
//   taken_cnt  saturating count of taken redirects
//  Modports: master = D-stage side (drives requests), slave = npc_ctrl.
interface npc_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);

    logic                 stall;
    logic [31:0]          D_PC;
    logic [2:0]           D_nPC_sel;
    logic [25:0]          D_imm26;
    logic [31:0]          D_RD1;
    logic                 isSame;
    logic                 isNega;
    logic [31:0]          F_PC;
    logic                 D_flush;
    logic                 redirect;
    logic [CNT_WIDTH-1:0] taken_cnt;

    modport master (
        output stall, D_PC, D_nPC_sel, D_imm26, D_RD1, isSame, isNega,
        input  F_PC, D_flush, redirect, taken_cnt
    );

    modport slave (
        input  stall, D_PC, D_nPC_sel, D_imm26, D_RD1, isSame, isNega,
        output F_PC, D_flush, redirect, taken_cnt
    );

endinterface

// File: rtl/npc_ctrl_target.sv
// npc_ctrl_target
//  Combinational redirect-target generator. Computes the address fetch would
//  move to if the D instruction is taken; whether it is taken is decided by
//  the caller.
//  Ports:
//   dPc     in   32  PC of the D instruction
//   imm26   in   26  instr[25:0]; imm16 = imm26[15:0]
//   rd1     in   32  forwarded rs value, used verbatim for register jumps
//   sel     in   3   next-PC select code
//   target  out  32  redirect target (branch target for non-jump codes)
module npc_ctrl_target
    import npc_ctrl_pkg::*;
(
    input  logic [31:0] dPc,
    input  logic [25:0] imm26,
    input  logic [31:0] rd1,
    input  logic [2:0]  sel,
    output logic [31:0] target
);

    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;

    // Offset is relative to the delay slot; 32-bit modulo, no overflow check.
    assign branchTarget = dPc + 32'd4 + (sext16(imm26[15:0]) << 2);

    // Region-relative jump keeps the top nibble of the owner's PC.
    assign jumpTarget = {dPc[31:28], imm26, 2'b00};

    always_comb begin
        target = branchTarget;
        case (sel)
            NPC_J:   target = jumpTarget;
            NPC_JR:  target = rd1;  // misaligned values pass through untouched
            default: target = branchTarget;
        endcase
    end

endmodule

// File: rtl/npc_ctrl.sv
// npc_ctrl
//  Fetch-side next-PC controller. Owns the F-stage PC register, turns the
//  D-stage select code plus comparator flags into the next fetch address,
//  squashes the delay slot of a not-taken branch-likely, freezes on stall and
//  keeps a saturating count of taken redirects.
//  Parameters:
//   PC_RESET   F_PC value after reset
//   CNT_WIDTH  width of the taken-redirect counter
//  Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low
//   bus    slave modport of npc_ctrl_if (D-stage inputs, fetch outputs)
module npc_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    npc_ctrl_if.slave bus
);

    npcDecode_t           dec;
    logic [31:0]          target;
    logic [31:0]          pcD;
    logic [31:0]          pcQ;
    logic                 redirectQ;
    logic [CNT_WIDTH-1:0] takenCntQ;

    npc_ctrl_target u_target (
        .dPc    (bus.D_PC),
        .imm26  (bus.D_imm26),
        .rd1    (bus.D_RD1),
        .sel    (bus.D_nPC_sel),
        .target (target)
    );

    always_comb begin
        dec = npcDecode(bus.D_nPC_sel, bus.isSame, bus.isNega);
        // The delay slot is already in F, so the fall-through is F_PC + 4.
        pcD = dec.taken ? target : pcQ + 32'd4;
    end

    // Stall wins so a frozen D-stage branch never squashes; it is re-evaluated
    // with fresh forwarded flags once released.
    assign bus.D_flush = dec.likely && !bus.isSame && !bus.stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcQ       <= PC_RESET;
            redirectQ <= 1'b0;
            takenCntQ <= '0;
        end else if (!bus.stall) begin
            pcQ       <= pcD;
            redirectQ <= dec.taken;
            if (dec.taken && !(&takenCntQ)) begin
                takenCntQ <= takenCntQ + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.F_PC      = pcQ;
    assign bus.redirect  = redirectQ;
    assign bus.taken_cnt = takenCntQ;

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl
//  Directed bench for npc_ctrl. Two instances share one stimulus stream: a
//  16-bit counter instance and a 2-bit counter instance (saturation). A
//  behavioural model computes F_PC / redirect / taken_cnt / D_flush from the
//  architectural rules and is compared every negedge; literal checks pin the
//  model at the interesting points.
module tb_npc_ctrl;

    localparam logic [31:0] PcReset = 32'h0000_3000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    npc_ctrl_if #(.CNT_WIDTH(16)) busA ();
    npc_ctrl_if #(.CNT_WIDTH(2))  busB ();

    npc_ctrl #(.PC_RESET(PcReset), .CNT_WIDTH(16)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    npc_ctrl #(.PC_RESET(PcReset), .CNT_WIDTH(2)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic wantTaken(input logic [2:0] sel, input logic same,
                                       input logic nega);
        case (sel)
            3'd1:    return same;
            3'd2:    return !same;
            3'd3:    return nega;
            3'd4:    return same;
            3'd5:    return 1'b1;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wantTarget(input logic [2:0] sel, input logic [31:0] dpc,
                                               input logic [25:0] imm, input logic [31:0] rd1);
        int off;
        if (sel == 3'd5) return (dpc & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
        if (sel == 3'd6) return rd1;
        off = $signed(imm[15:0]) * 4;
        return dpc + 32'd4 + 32'(off);
    endfunction

    logic [31:0] mPc       = PcReset;
    logic        mRedirect = 1'b0;
    int          mCntA     = 0;
    int          mCntB     = 0;
    logic        mTaken;
    logic        mFlush;

    assign mTaken = wantTaken(busA.D_nPC_sel, busA.isSame, busA.isNega);
    assign mFlush = (busA.D_nPC_sel == 3'd4) && !busA.isSame && !busA.stall;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mPc       <= PcReset;
            mRedirect <= 1'b0;
            mCntA     <= 0;
            mCntB     <= 0;
        end else if (!busA.stall) begin
            mPc       <= mTaken ? wantTarget(busA.D_nPC_sel, busA.D_PC, busA.D_imm26,
                                             busA.D_RD1)
                                : mPc + 32'd4;
            mRedirect <= mTaken;
            if (mTaken && mCntA < 65535) mCntA <= mCntA + 1;
            if (mTaken && mCntB < 3)     mCntB <= mCntB + 1;
        end
    end

    always @(negedge clk) begin
        check("F_PC",         busA.F_PC,            mPc);
        check("F_PC w2",      busB.F_PC,            mPc);
        check("redirect",     32'(busA.redirect),   32'(mRedirect));
        check("redirect w2",  32'(busB.redirect),   32'(mRedirect));
        check("taken_cnt",    32'(busA.taken_cnt),  32'(mCntA));
        check("taken_cnt w2", 32'(busB.taken_cnt),  32'(mCntB));
        check("D_flush",      32'(busA.D_flush),    32'(mFlush));
        check("D_flush w2",   32'(busB.D_flush),    32'(mFlush));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] sel, input logic [31:0] dpc, input logic [25:0] imm,
                         input logic [31:0] rd1, input logic same, input logic nega,
                         input logic stl);
        busA.D_nPC_sel = sel; busB.D_nPC_sel = sel;
        busA.D_PC      = dpc; busB.D_PC      = dpc;
        busA.D_imm26   = imm; busB.D_imm26   = imm;
        busA.D_RD1     = rd1; busB.D_RD1     = rd1;
        busA.isSame    = same; busB.isSame   = same;
        busA.isNega    = nega; busB.isNega   = nega;
        busA.stall     = stl; busB.stall     = stl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("lit reset F_PC", busA.F_PC, 32'h3000);
        check("lit reset cnt",  32'(busA.taken_cnt), 32'd0);
        reset = 1'b1;
        step(); check("lit seq 1", busA.F_PC, 32'h3004);
        step(); check("lit seq 2", busA.F_PC, 32'h3008);

        // BEQ taken / not taken
        drive(3'd1, 32'h3000, 26'h0003, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("lit beq F_PC",     busA.F_PC, 32'h3010);
        check("lit beq redirect", 32'(busA.redirect), 32'd1);
        check("lit beq cnt",      32'(busA.taken_cnt), 32'd1);
        drive(3'd1, 32'h3004, 26'h0003, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("lit beq nt F_PC", busA.F_PC, 32'h3014);

        // BEQL not taken: flush, then frozen by stall
        drive(3'd4, 32'h3010, 26'h0008, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 check("lit beql flush", 32'(busA.D_flush), 32'd1);
        step(); check("lit beql F_PC", busA.F_PC, 32'h3018);
        drive(3'd4, 32'h3014, 26'h0008, 32'h0, 1'b0, 1'b0, 1'b1);
        #1 check("lit beql stall flush", 32'(busA.D_flush), 32'd0);
        step(); check("lit beql stall F_PC", busA.F_PC, 32'h3018);

        // Register jump (misaligned) and region jump
        drive(3'd6, 32'h3014, 26'h0, 32'h0000_3FFE, 1'b0, 1'b0, 1'b0);
        step(); check("lit jr F_PC", busA.F_PC, 32'h3FFE);
        drive(3'd5, 32'h3000, 26'h0000C10, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check("lit j F_PC", busA.F_PC, 32'h3040);

        // Taken branch held by stall for 3 cycles, then released
        drive(3'd1, 32'h3040, 26'h0001, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lit stall F_PC", busA.F_PC, 32'h3040);
            check("lit stall cnt",  32'(busA.taken_cnt), 32'd3);
        end
        drive(3'd1, 32'h3040, 26'h0001, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("lit unstall F_PC", busA.F_PC, 32'h3048);
        check("lit unstall cnt",  32'(busA.taken_cnt), 32'd4);

        // BNEG backwards to itself; fifth taken saturates the 2-bit counter
        drive(3'd3, 32'h3008, 26'h000FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        check("lit bneg F_PC", busA.F_PC, 32'h3008);
        check("lit cnt16 5",   32'(busA.taken_cnt), 32'd5);
        check("lit cnt2 sat",  32'(busB.taken_cnt), 32'd3);

        // BNE both ways, then the unused code 7
        drive(3'd2, 32'h3008, 26'h0010, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check("lit bne t F_PC", busA.F_PC, 32'h304C);
        drive(3'd2, 32'h3008, 26'h0010, 32'h0, 1'b1, 1'b0, 1'b0);
        step(); check("lit bne nt F_PC", busA.F_PC, 32'h3050);
        drive(3'd7, 32'h3008, 26'h0010, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 check("lit code7 flush", 32'(busA.D_flush), 32'd0);
        step(); check("lit code7 F_PC", busA.F_PC, 32'h3054);

        // Address wrap
        drive(3'd6, 32'h3050, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        step(); check("lit jr top", busA.F_PC, 32'hFFFF_FFFC);
        drive(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check("lit wrap", busA.F_PC, 32'h0);

        // Reset mid-run (and mid-stall) at F_PC=0x3010
        drive(3'd5, 32'h0, 26'h0000C04, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("lit pre-reset F_PC", busA.F_PC, 32'h3010);
        check("lit pre-reset cnt",  32'(busA.taken_cnt), 32'd8);
        drive(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("lit async F_PC",     busA.F_PC, 32'h3000);
        check("lit async cnt",      32'(busA.taken_cnt), 32'd0);
        check("lit async redirect", 32'(busA.redirect), 32'd0);
        step();
        reset = 1'b1;
        drive(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check("lit post-reset 1", busA.F_PC, 32'h3004);
        step(); check("lit post-reset 2", busA.F_PC, 32'h3008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
